// File: rtl/mii_rx_frame.sv
// ----------------------------------------------------------------------------
// mii_rx_frame
// Byte-level Ethernet receive framer. Sits behind the MII nibble-to-byte
// assembler, strips preamble/SFD, forwards DA..payload with the 4-byte FCS
// held back in a delay line, checks CRC-32 (residue method) and frame length,
// and reports per-frame status on a one-cycle end-of-frame pulse.
//
// Ports
//   mii_clk    in   receive clock (single clock domain)
//   reset      in   synchronous, active-high
//   in_en      in   frame-active level (RX_DV)
//   in_rdy     in   one-cycle strobe, in_data valid
//   in_data    in   [7:0] received byte, bit 0 first on the wire
//   out_valid  out  one-cycle strobe, out_data valid
//   out_data   out  [7:0] frame byte (FCS never forwarded)
//   out_sof    out  with out_valid on the first frame byte
//   out_eof    out  one-cycle end-of-frame strobe, status valid
//   frame_len  out  [15:0] DATA bytes minus 4, floored at 0
//   crc_err    out  CRC residue mismatch
//   len_err    out  length outside [MIN_LEN, MAX_LEN]
//   frame_ok   out  !crc_err && !len_err
// Status outputs hold until the next out_eof or reset.
// ----------------------------------------------------------------------------
module mii_rx_frame #(
   parameter int PRE_MIN = 1,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        mii_clk,
   input  logic        reset,
   input  logic        in_en,
   input  logic        in_rdy,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        out_eof,
   output logic [15:0] frame_len,
   output logic        crc_err,
   output logic        len_err,
   output logic        frame_ok
);

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [4:0]  PRE_MIN_W   = 5'(PRE_MIN);
   localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
   localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);
   localparam logic [7:0]  BYTE_PRE    = 8'h55;
   localparam logic [7:0]  BYTE_SFD    = 8'hD5;

   // Reflected CRC-32 update over one byte, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if ((c[0] ^ data[i]) == 1'b1) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [3:0]        pre_cnt;
   logic [15:0]       byte_cnt;
   logic [31:0]       crc;
   logic [3:0][7:0]   dly;       // dly[0] newest, dly[3] is byte n-4
   logic              end_evt;
   logic              sfd_ok;
   logic              crc_bad;
   logic              len_bad;

   // The byte strobe lags RX_DV by a cycle, so a frame only ends once both are low.
   assign end_evt = (state != ST_IDLE) && !in_en && !in_rdy;
   assign sfd_ok  = ({1'b0, pre_cnt} >= PRE_MIN_W);
   assign crc_bad = (crc != CRC_RESIDUE);
   assign len_bad = (byte_cnt < MIN_LEN_W) || (byte_cnt > MAX_LEN_W);

   // State register.
   always_ff @(posedge mii_clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (in_en) begin
               state_nx = ST_PRE;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (end_evt) begin
               state_nx = ST_IDLE;
            end else if (in_rdy) begin
               if (in_data == BYTE_PRE) begin
                  state_nx = ST_PRE;
               end else if ((in_data == BYTE_SFD) && sfd_ok) begin
                  state_nx = ST_DATA;
               end else begin
                  state_nx = ST_DROP;
               end
            end else begin
               state_nx = ST_PRE;
            end
         end
         ST_DATA: begin
            if (end_evt) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_DATA;
            end
         end
         ST_DROP: begin
            if (end_evt) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_DROP;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Counters, CRC, delay line and all registered outputs.
   always_ff @(posedge mii_clk) begin
      if (reset) begin
         pre_cnt   <= 4'd0;
         byte_cnt  <= 16'd0;
         crc       <= CRC_INIT;
         dly       <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'd0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         frame_len <= 16'd0;
         crc_err   <= 1'b0;
         len_err   <= 1'b0;
         frame_ok  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_en) begin
                  pre_cnt <= 4'd0;
               end
            end
            ST_PRE: begin
               if (in_rdy) begin
                  if (in_data == BYTE_PRE) begin
                     if (pre_cnt != 4'hF) begin
                        pre_cnt <= pre_cnt + 4'd1;
                     end
                  end else if ((in_data == BYTE_SFD) && sfd_ok) begin
                     crc      <= CRC_INIT;
                     byte_cnt <= 16'd0;
                  end
               end
            end
            ST_DATA: begin
               if (in_rdy) begin
                  crc <= crc32_byte(crc, in_data);
                  if (byte_cnt != 16'hFFFF) begin
                     byte_cnt <= byte_cnt + 16'd1;
                  end
                  dly <= {dly[2:0], in_data};
                  // Byte n-4 leaves the delay line as byte n arrives; the
                  // last four (the FCS) never do.
                  if (byte_cnt >= 16'd4) begin
                     out_valid <= 1'b1;
                     out_data  <= dly[3];
                     out_sof   <= (byte_cnt == 16'd4);
                  end
               end else if (end_evt) begin
                  out_eof   <= 1'b1;
                  frame_len <= (byte_cnt < 16'd4) ? 16'd0 : (byte_cnt - 16'd4);
                  crc_err   <= crc_bad;
                  len_err   <= len_bad;
                  frame_ok  <= !crc_bad && !len_bad;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mii_rx_frame.sv
// ----------------------------------------------------------------------------
// tb_mii_rx_frame
// Directed frames drive three framer instances in parallel (default limits,
// MIN_LEN=13, PRE_MIN=4). A frame-level model derives, per instance, the byte
// stream and end-of-frame status each frame must produce; a single compare
// process checks every cycle against it, and literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_mii_rx_frame;

   logic        mii_clk;
   logic        reset;
   logic        in_en;
   logic        in_rdy;
   logic [7:0]  in_data;

   logic        ov [3];
   logic [7:0]  od [3];
   logic        os [3];
   logic        oe [3];
   logic [15:0] fl [3];
   logic        ce [3];
   logic        le [3];
   logic        fo [3];

   int pmin [3] = '{1, 1, 4};
   int minl [3] = '{64, 13, 64};
   int maxl [3] = '{1518, 1518, 1518};

   int errors = 0;
   int checks = 0;
   int nvalid [3] = '{0, 0, 0};
   int neof   [3] = '{0, 0, 0};

   logic [8:0]  exp_byte [3][$];   // {sof, data}
   logic [18:0] exp_stat [3][$];   // {frame_len, crc_err, len_err, frame_ok}
   logic [18:0] held [3];
   logic [8:0]  eb;

   logic [7:0]  fq [$];
   int          data_start;

   mii_rx_frame u0 (
      .mii_clk(mii_clk), .reset(reset), .in_en(in_en), .in_rdy(in_rdy), .in_data(in_data),
      .out_valid(ov[0]), .out_data(od[0]), .out_sof(os[0]), .out_eof(oe[0]),
      .frame_len(fl[0]), .crc_err(ce[0]), .len_err(le[0]), .frame_ok(fo[0]));

   mii_rx_frame #(.MIN_LEN(13)) u1 (
      .mii_clk(mii_clk), .reset(reset), .in_en(in_en), .in_rdy(in_rdy), .in_data(in_data),
      .out_valid(ov[1]), .out_data(od[1]), .out_sof(os[1]), .out_eof(oe[1]),
      .frame_len(fl[1]), .crc_err(ce[1]), .len_err(le[1]), .frame_ok(fo[1]));

   mii_rx_frame #(.PRE_MIN(4)) u2 (
      .mii_clk(mii_clk), .reset(reset), .in_en(in_en), .in_rdy(in_rdy), .in_data(in_data),
      .out_valid(ov[2]), .out_data(od[2]), .out_sof(os[2]), .out_eof(oe[2]),
      .frame_len(fl[2]), .crc_err(ce[2]), .len_err(le[2]), .frame_ok(fo[2]));

   initial mii_clk = 1'b0;
   always #5 mii_clk = ~mii_clk;

   // Standard Ethernet CRC-32 of the first n bytes (final value, complemented).
   function automatic logic [31:0] crc32_of(input logic [7:0] d [$], input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, d[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Frame model: what each instance must forward and report for the frame in fq.
   task automatic model_frame(input bit abort);
      int cnt, ds, n;
      logic [7:0] d [$];
      logic [31:0] fcs;
      bit cerr, lerr;
      for (int c = 0; c < 3; c++) begin
         cnt = 0;
         ds  = -1;
         for (int i = 0; i < fq.size(); i++) begin
            if (fq[i] == 8'h55) begin
               if (cnt < 15) cnt++;
            end else begin
               if (fq[i] == 8'hD5 && cnt >= pmin[c]) ds = i + 1;
               break;
            end
         end
         if (ds < 0) continue;
         d.delete();
         for (int i = ds; i < fq.size(); i++) d.push_back(fq[i]);
         n = d.size();
         for (int k = 0; k + 4 < n; k++) exp_byte[c].push_back({(k == 0), d[k]});
         if (abort) continue;
         if (n < 4) begin
            cerr = 1'b1;
         end else begin
            fcs  = {d[n-1], d[n-2], d[n-3], d[n-4]};
            cerr = (crc32_of(d, n - 4) != fcs);
         end
         lerr = (n < minl[c]) || (n > maxl[c]);
         exp_stat[c].push_back({16'((n < 4) ? 0 : n - 4), cerr, lerr, !cerr && !lerr});
      end
   endtask

   task automatic tick(input logic en, input logic rdy, input logic [7:0] d);
      in_en   = en;
      in_rdy  = rdy;
      in_data = d;
      @(posedge mii_clk);
      #1;
   endtask

   task automatic fq_start(input int npre);
      fq.delete();
      repeat (npre) fq.push_back(8'h55);
      fq.push_back(8'hD5);
      data_start = fq.size();
   endtask

   task automatic fq_payload(input int n, input int base);
      for (int i = 0; i < n; i++) fq.push_back(8'((base + i) % 256));
   endtask

   task automatic fq_fcs();
      logic [7:0] t [$];
      logic [31:0] c;
      for (int i = data_start; i < fq.size(); i++) t.push_back(fq[i]);
      c = crc32_of(t, t.size());
      fq.push_back(c[7:0]);
      fq.push_back(c[15:8]);
      fq.push_back(c[23:16]);
      fq.push_back(c[31:24]);
   endtask

   task automatic check_drained(input string name);
      for (int c = 0; c < 3; c++) begin
         check({name, " pending bytes"}, exp_byte[c].size(), 0);
         check({name, " pending eof"}, exp_stat[c].size(), 0);
      end
   endtask

   // Wire the frame in fq: RX_DV rises, bytes follow (every cycle or every
   // other cycle), the last strobe lags RX_DV, then one end cycle.
   task automatic send(input int cadence, input bit b2b, input string name);
      bit last;
      model_frame(1'b0);
      tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < fq.size(); i++) begin
         last = (i == fq.size() - 1);
         tick(!last, 1'b1, fq[i]);
         if (cadence == 2 && !last) tick(1'b1, 1'b0, 8'h00);
      end
      tick(1'b0, 1'b0, 8'h00);
      if (!b2b) begin
         repeat (3) tick(1'b0, 1'b0, 8'h00);
         check_drained(name);
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   always @(negedge mii_clk) begin
      if (reset === 1'b0) begin
         for (int c = 0; c < 3; c++) begin
            if (ov[c] === 1'b1 && oe[c] === 1'b1) begin
               errors++;
               $display("FAIL overlap u%0d: valid and eof together", c);
            end
            checks++;
            if (ov[c] === 1'b1) begin
               nvalid[c]++;
               if (exp_byte[c].size() == 0) begin
                  errors++;
                  $display("FAIL spurious valid u%0d: got data %h expected none", c, od[c]);
               end else begin
                  eb = exp_byte[c].pop_front();
                  if ({os[c], od[c]} !== eb) begin
                     errors++;
                     $display("FAIL data u%0d: got sof=%b data=%h expected sof=%b data=%h",
                              c, os[c], od[c], eb[8], eb[7:0]);
                  end
               end
            end else if (os[c] !== 1'b0 || ov[c] !== 1'b0) begin
               errors++;
               $display("FAIL idle u%0d: got valid=%b sof=%b expected 0 0", c, ov[c], os[c]);
            end
            if (oe[c] === 1'b1) begin
               neof[c]++;
               checks++;
               if (exp_stat[c].size() == 0) begin
                  errors++;
                  $display("FAIL spurious eof u%0d: got eof expected none", c);
               end else begin
                  held[c] = exp_stat[c].pop_front();
               end
            end else if (oe[c] !== 1'b0) begin
               errors++;
               $display("FAIL eof level u%0d: got %b expected 0", c, oe[c]);
            end
            checks++;
            if ({fl[c], ce[c], le[c], fo[c]} !== held[c]) begin
               errors++;
               $display("FAIL status u%0d: got len=%0d crc=%b len_err=%b ok=%b expected len=%0d crc=%b len_err=%b ok=%b",
                        c, fl[c], ce[c], le[c], fo[c],
                        held[c][18:3], held[c][2], held[c][1], held[c][0]);
            end
         end
      end
   end

   initial begin
      logic [7:0] t [$];
      int v0, e0, v1, e1, v2, e2;

      for (int c = 0; c < 3; c++) held[c] = 19'd0;
      reset = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      @(negedge mii_clk);
      check("reset out_valid", ov[0], 0);
      check("reset out_eof", oe[0], 0);
      check("reset frame_len", fl[0], 0);
      check("reset frame_ok", fo[0], 0);

      // Model pin: CRC-32 check value of "123456789".
      t = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check("crc model pin", crc32_of(t, 9), 32'hCBF4_3926);

      // Golden frame, every other cycle then every cycle.
      for (int cad = 2; cad >= 1; cad--) begin
         fq_start(7); fq_payload(60, 0); fq_fcs();
         v0 = nvalid[0]; e0 = neof[0];
         send(cad, 1'b0, "golden");
         check("golden valid count", nvalid[0] - v0, 60);
         check("golden eof count", neof[0] - e0, 1);
         check("golden frame_len", fl[0], 60);
         check("golden frame_ok", fo[0], 1);
      end

      // CRC check vector, literal FCS bytes.
      fq_start(1);
      fq.push_back(8'h31); fq.push_back(8'h32); fq.push_back(8'h33);
      fq.push_back(8'h34); fq.push_back(8'h35); fq.push_back(8'h36);
      fq.push_back(8'h37); fq.push_back(8'h38); fq.push_back(8'h39);
      fq.push_back(8'h26); fq.push_back(8'h39); fq.push_back(8'hF4); fq.push_back(8'hCB);
      send(1, 1'b0, "crcvec");
      check("crcvec u1 frame_len", fl[1], 9);
      check("crcvec u1 crc_err", ce[1], 0);
      check("crcvec u1 frame_ok", fo[1], 1);
      check("crcvec u0 len_err", le[0], 1);
      fq[data_start + 4] = 8'h34;
      send(2, 1'b0, "crcflip");
      check("crcflip u1 crc_err", ce[1], 1);
      check("crcflip u1 frame_ok", fo[1], 0);

      // Bad preamble byte.
      fq.delete();
      repeat (3) fq.push_back(8'h55);
      fq.push_back(8'h57); fq.push_back(8'hD5);
      data_start = fq.size();
      fq_payload(60, 7);
      v0 = nvalid[0]; e0 = neof[0]; v2 = nvalid[2]; e2 = neof[2];
      send(1, 1'b0, "badpre");
      check("badpre valid count", nvalid[0] - v0, 0);
      check("badpre eof count", neof[0] - e0, 0);
      check("badpre u2 valid count", nvalid[2] - v2, 0);
      check("badpre u2 eof count", neof[2] - e2, 0);

      // Short preamble: accepted with PRE_MIN=1, dropped with PRE_MIN=4.
      fq_start(2); fq_payload(60, 3); fq_fcs();
      v2 = nvalid[2]; e2 = neof[2];
      send(1, 1'b0, "shortpre");
      check("shortpre u2 valid count", nvalid[2] - v2, 0);
      check("shortpre u2 eof count", neof[2] - e2, 0);
      check("shortpre u0 frame_ok", fo[0], 1);

      // Runt of 20 DATA bytes.
      fq_start(7); fq_payload(16, 9); fq_fcs();
      v0 = nvalid[0];
      send(2, 1'b0, "runt");
      check("runt valid count", nvalid[0] - v0, 16);
      check("runt frame_len", fl[0], 16);
      check("runt len_err", le[0], 1);
      check("runt crc_err", ce[0], 0);

      // One below the minimum length.
      fq_start(7); fq_payload(59, 1); fq_fcs();
      send(1, 1'b0, "len63");
      check("len63 len_err", le[0], 1);

      // Maximum legal length, then one byte beyond.
      fq_start(7); fq_payload(1514, 5); fq_fcs();
      send(1, 1'b0, "len1518");
      check("len1518 frame_ok", fo[0], 1);
      check("len1518 frame_len", fl[0], 1514);
      fq_start(7); fq_payload(1515, 5); fq_fcs();
      v0 = nvalid[0];
      send(1, 1'b0, "giant");
      check("giant valid count", nvalid[0] - v0, 1515);
      check("giant len_err", le[0], 1);
      check("giant frame_ok", fo[0], 0);

      // Three DATA bytes only.
      fq_start(1);
      fq.push_back(8'hAA); fq.push_back(8'hBB); fq.push_back(8'hCC);
      v0 = nvalid[0]; e0 = neof[0];
      send(1, 1'b0, "tiny");
      check("tiny valid count", nvalid[0] - v0, 0);
      check("tiny eof count", neof[0] - e0, 1);
      check("tiny frame_len", fl[0], 0);
      check("tiny len_err", le[0], 1);

      // Reset after the 30th DATA byte, then a golden frame straight away.
      fq_start(7); fq_payload(30, 0);
      model_frame(1'b1);
      e0 = neof[0];
      tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < fq.size(); i++) tick(1'b1, 1'b1, fq[i]);
      tick(1'b1, 1'b0, 8'h00);
      check_drained("abort");
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         held[c] = 19'd0;
         exp_byte[c].delete();
         exp_stat[c].delete();
      end
      tick(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      @(negedge mii_clk);
      check("abort out_valid", ov[0], 0);
      check("abort frame_len", fl[0], 0);
      fq_start(7); fq_payload(60, 0); fq_fcs();
      send(1, 1'b0, "after reset");
      check("abort eof count", neof[0] - e0, 1);
      check("after reset frame_ok", fo[0], 1);

      // Back-to-back: second RX_DV rises in the first frame's eof cycle.
      e1 = neof[1];
      fq_start(7); fq_payload(60, 16'h10); fq_fcs();
      send(1, 1'b1, "b2b first");
      fq_start(7); fq_payload(61, 16'h80); fq_fcs();
      send(2, 1'b0, "b2b second");
      check("b2b eof count", neof[1] - e1, 2);
      check("b2b frame_len", fl[1], 61);
      check("b2b frame_ok", fo[1], 1);
      v1 = nvalid[1];
      check("b2b u1 total valids nonzero", (v1 > 0), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
